// File: rtl/spm_port_arbiter_pkg.sv
// Shared encodings for the scratch-pad port arbiter: access direction,
// read-return owner and the default starvation limit.
package spm_port_arbiter_pkg;

    // Access direction encoding shared with mem_ctrl and the spm port
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Width of the TEST starvation counter and its default limit
    localparam int unsigned STARVE_W       = 4;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Which requester owns the read data returning next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_TEST = 2'd2
    } owner_e;

endpackage

// File: rtl/spm_port_arbiter.sv
// Cycle-level arbiter sharing the scratch-pad data port between the pipeline
// MEM stage (CPU) and the test/debug port (TEST). The SPM access happens in
// the grant cycle; read data one cycle later is steered to the issuing side.
module spm_port_arbiter
    import spm_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              cpu_as_,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rd_valid,
    input  logic              test_as_,
    input  logic              test_rw,
    input  logic [ADDR_W-1:0] test_addr,
    input  logic [DATA_W-1:0] test_wr_data,
    output logic              test_ack,
    output logic [DATA_W-1:0] test_rd_data,
    output logic              test_rd_valid,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic                cpu_req;
    logic                test_req;
    logic                cpu_grant;
    logic                test_grant;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_cnt_nxt;
    owner_e              rd_owner;
    owner_e              rd_owner_nxt;

    // Grant decision: TEST owns the port when CPU arbitration is off;
    // otherwise CPU wins unless it is idle or TEST has starved long enough
    always_comb begin
        cpu_req    = ~cpu_as_;
        test_req   = ~test_as_;
        cpu_grant  = 1'b0;
        test_grant = 1'b0;
        if (!cpu_en) begin
            test_grant = test_req;
        end else if (test_req && (!cpu_req || starve_cnt == STARVE_LIM)) begin
            test_grant = 1'b1;
        end else begin
            cpu_grant = cpu_req;
        end
    end

    // Requester-facing handshakes
    always_comb begin
        cpu_stall = cpu_en & cpu_req & ~cpu_grant;
        test_ack  = test_grant;
    end

    // SPM port mux; an idle port presents a parked read of address zero
    always_comb begin
        spm_as_     = 1'b1;
        spm_rw      = READ;
        spm_addr    = '0;
        spm_wr_data = '0;
        if (test_grant) begin
            spm_as_     = 1'b0;
            spm_rw      = test_rw;
            spm_addr    = test_addr;
            spm_wr_data = test_wr_data;
        end else if (cpu_grant) begin
            spm_as_     = 1'b0;
            spm_rw      = cpu_rw;
            spm_addr    = cpu_addr;
            spm_wr_data = cpu_wr_data;
        end
    end

    // Next starvation count and read owner
    always_comb begin
        starve_cnt_nxt = '0;
        rd_owner_nxt   = OWN_NONE;
        if (test_req && !test_grant) begin
            starve_cnt_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt
                                                        : starve_cnt + STARVE_W'(1);
        end
        if (test_grant && test_rw == READ) begin
            rd_owner_nxt = OWN_TEST;
        end else if (cpu_grant && cpu_rw == READ) begin
            rd_owner_nxt = OWN_CPU;
        end
    end

    // State registers; reset drops any pending read return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            rd_owner   <= OWN_NONE;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            rd_owner   <= rd_owner_nxt;
        end
    end

    // Steer returning read data to its owner; the other side sees zero
    always_comb begin
        cpu_rd_valid  = (rd_owner == OWN_CPU);
        test_rd_valid = (rd_owner == OWN_TEST);
        cpu_rd_data   = cpu_rd_valid  ? spm_rd_data : '0;
        test_rd_data  = test_rd_valid ? spm_rd_data : '0;
    end

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Directed bench for spm_port_arbiter: each stimulus cycle pushes its
// hand-computed expectation, and a negedge monitor pops and compares.
module tb_spm_port_arbiter;
    import spm_port_arbiter_pkg::*;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_en;
    logic          cpu_as_;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_rd_valid;
    logic          test_as_;
    logic          test_rw;
    logic [AW-1:0] test_addr;
    logic [DW-1:0] test_wr_data;
    logic          test_ack;
    logic [DW-1:0] test_rd_data;
    logic          test_rd_valid;
    logic          spm_as_;
    logic          spm_rw;
    logic [AW-1:0] spm_addr;
    logic [DW-1:0] spm_wr_data;
    logic [DW-1:0] spm_rd_data;

    spm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en),
        .cpu_as_(cpu_as_), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_stall(cpu_stall),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
        .test_as_(test_as_), .test_rw(test_rw), .test_addr(test_addr),
        .test_wr_data(test_wr_data), .test_ack(test_ack),
        .test_rd_data(test_rd_data), .test_rd_valid(test_rd_valid),
        .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
    );

    always #5 clk = ~clk;

    // Small SPM: read data valid the cycle after a read access
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (!spm_as_) begin
            if (spm_rw == READ) spm_rd_data <= mem[spm_addr[7:0]];
            else                mem[spm_addr[7:0]] <= spm_wr_data;
        end
    end

    typedef struct {
        int            cyc;
        logic          stall;
        logic          ack;
        logic          as_n;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          crv;
        logic [DW-1:0] crd;
        logic          trv;
        logic [DW-1:0] trd;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc_no = 0;

    task automatic chk(input string nm, input int cyc, input logic [DW-1:0] act,
                       input logic [DW-1:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
    endtask

    // Monitor: compare one expectation per cycle, away from the clock edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("cpu_stall",     e.cyc, DW'(cpu_stall),     DW'(e.stall));
            chk("test_ack",      e.cyc, DW'(test_ack),      DW'(e.ack));
            chk("spm_as_",       e.cyc, DW'(spm_as_),       DW'(e.as_n));
            chk("spm_rw",        e.cyc, DW'(spm_rw),        DW'(e.rw));
            chk("spm_addr",      e.cyc, DW'(spm_addr),      DW'(e.addr));
            chk("spm_wr_data",   e.cyc, spm_wr_data,        e.wd);
            chk("cpu_rd_valid",  e.cyc, DW'(cpu_rd_valid),  DW'(e.crv));
            chk("cpu_rd_data",   e.cyc, cpu_rd_data,        e.crd);
            chk("test_rd_valid", e.cyc, DW'(test_rd_valid), DW'(e.trv));
            chk("test_rd_data",  e.cyc, test_rd_data,       e.trd);
        end
    end

    // Drive one cycle of inputs and queue the expected response for it
    task automatic step(input logic rst_v, input logic cen,
                        input logic cas, input logic crw,
                        input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                        input logic tas, input logic trw,
                        input logic [AW-1:0] ta, input logic [DW-1:0] twd,
                        input logic e_stall, input logic e_ack,
                        input logic e_crv, input logic [DW-1:0] e_crd,
                        input logic e_trv, input logic [DW-1:0] e_trd);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v; cpu_en = cen;
        cpu_as_ = cas; cpu_rw = crw; cpu_addr = ca; cpu_wr_data = cwd;
        test_as_ = tas; test_rw = trw; test_addr = ta; test_wr_data = twd;
        e.cyc = cyc_no; cyc_no++;
        e.stall = e_stall; e.ack = e_ack;
        e.crv = e_crv; e.crd = e_crd; e.trv = e_trv; e.trd = e_trd;
        if (e_ack) begin
            e.as_n = 1'b0; e.rw = trw; e.addr = ta; e.wd = twd;
        end else if (cen && !cas && !e_stall) begin
            e.as_n = 1'b0; e.rw = crw; e.addr = ca; e.wd = cwd;
        end else begin
            e.as_n = 1'b1; e.rw = READ; e.addr = '0; e.wd = '0;
        end
        q.push_back(e);
    endtask

    task automatic idle(input logic rst_v, input logic cen,
                        input logic e_crv, input logic [DW-1:0] e_crd,
                        input logic e_trv, input logic [DW-1:0] e_trd);
        step(rst_v, cen, 1'b1, READ, '0, '0, 1'b1, READ, '0, '0,
             1'b0, 1'b0, e_crv, e_crd, e_trv, e_trd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEAD_BEEF;
        spm_rd_data = '0;
        reset = 1'b0; cpu_en = 1'b1;
        cpu_as_ = 1'b1; cpu_rw = READ; cpu_addr = '0; cpu_wr_data = '0;
        test_as_ = 1'b1; test_rw = READ; test_addr = '0; test_wr_data = '0;

        // Reset state, then both idle
        idle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);

        // CPU read of 0x10 returns DEADBEEF next cycle
        step(1'b1, 1'b1, 1'b0, READ, 30'h10, '0, 1'b1, READ, '0, '0,
             1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        idle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);

        // CPU writes every cycle; TEST read starves 4 cycles then wins
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, WRITE, AW'(32'h30 + i), DW'(i), 1'b0, READ, 30'h10, '0,
                 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, WRITE, 30'h34, 32'h4, 1'b0, READ, 30'h10, '0,
             1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);

        // cpu_en=0: TEST owns the port, CPU strobe is ignored without stall
        step(1'b1, 1'b0, 1'b0, READ, 30'h40, '0, 1'b0, WRITE, 30'h20, 32'h1234_5678,
             1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, READ, 30'h40, '0, 1'b0, READ, 30'h20, '0,
             1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h1234_5678);

        // CPU read then TEST read on consecutive cycles, no cross-steer
        step(1'b1, 1'b1, 1'b0, READ, 30'h10, '0, 1'b1, READ, '0, '0,
             1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, READ, '0, '0, 1'b0, READ, 30'h20, '0,
             1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
        idle(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h1234_5678);

        // Reset the cycle after a CPU read grant drops the return
        step(1'b1, 1'b1, 1'b0, READ, 30'h10, '0, 1'b1, READ, '0, '0,
             1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        idle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, READ, '0, '0, 1'b0, READ, 30'h20, '0,
             1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, READ, 30'h10, '0, 1'b1, READ, '0, '0,
             1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        idle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);

        // Starvation count restarts from zero after reset
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, WRITE, 30'h50, '0, 1'b0, READ, 30'h10, '0,
                 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, WRITE, 30'h50, '0, 1'b0, READ, 30'h10, '0,
             1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        idle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
